// File: rtl/branch_resolve_unit_pkg.sv
// Shared branch-unit types and default widths for the fcpu core.
package branch_resolve_unit_pkg;

  localparam int unsigned CRAM_ADDR_W = 16;
  localparam int unsigned RSV_ID_W    = 6;
  localparam int unsigned BR_DATA_W   = 32;
  localparam int unsigned BR_DEPTH_W  = 2;

  typedef enum logic [2:0] {
    BrBeq   = 3'd0,
    BrBne   = 3'd1,
    BrBlt   = 3'd2,
    BrBge   = 3'd3,
    BrBltu  = 3'd4,
    BrBgeu  = 3'd5,
    BrJal   = 3'd6,
    BrNever = 3'd7
  } br_op_t;

  typedef struct packed {
    logic [RSV_ID_W-1:0]  tag;
    logic [BR_DATA_W-1:0] val;
    logic                 filled;
  } br_src_t;

  typedef struct packed {
    logic                   valid;
    logic [RSV_ID_W-1:0]    tag;
    br_op_t                 op;
    br_src_t                src1;
    br_src_t                src2;
    logic                   pred_taken;
    logic [CRAM_ADDR_W-1:0] target;
    logic [CRAM_ADDR_W-1:0] fallthru;
  } br_entry_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Dispatch, CDB snoop, flush and resolution signals of the branch unit.
interface branch_resolve_unit_if
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = CRAM_ADDR_W,
  parameter int unsigned TAG_W  = RSV_ID_W
);
  logic              i_valid;
  logic              i_ready;
  logic [TAG_W-1:0]  i_tag;
  logic [2:0]        i_op;
  logic [TAG_W-1:0]  i_src1_tag;
  logic [TAG_W-1:0]  i_src2_tag;
  logic [DATA_W-1:0] i_src1_val;
  logic [DATA_W-1:0] i_src2_val;
  logic              i_src1_filled;
  logic              i_src2_filled;
  logic              i_pred_taken;
  logic [ADDR_W-1:0] i_target;
  logic [ADDR_W-1:0] i_fallthru;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              flush;
  logic              o_valid;
  logic [TAG_W-1:0]  o_tag;
  logic              o_taken;
  logic              pred_miss;
  logic [ADDR_W-1:0] pred_miss_dst;

  modport master (
    output i_valid, i_tag, i_op, i_src1_tag, i_src2_tag, i_src1_val, i_src2_val,
    output i_src1_filled, i_src2_filled, i_pred_taken, i_target, i_fallthru,
    output cdb_valid, cdb_tag, cdb_data, flush,
    input  i_ready, o_valid, o_tag, o_taken, pred_miss, pred_miss_dst
  );

  modport slave (
    input  i_valid, i_tag, i_op, i_src1_tag, i_src2_tag, i_src1_val, i_src2_val,
    input  i_src1_filled, i_src2_filled, i_pred_taken, i_target, i_fallthru,
    input  cdb_valid, cdb_tag, cdb_data, flush,
    output i_ready, o_valid, o_tag, o_taken, pred_miss, pred_miss_dst
  );

endinterface

// File: rtl/branch_resolve_unit_queue.sv
// In-order branch queue: circular FIFO with CDB operand snooping and head-ready flag.
module branch_resolve_unit_queue
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = CRAM_ADDR_W,
  parameter int unsigned TAG_W   = RSV_ID_W,
  parameter int unsigned DEPTH_W = BR_DEPTH_W
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [TAG_W-1:0]  enq_tag,
  input  br_op_t            enq_op,
  input  logic [TAG_W-1:0]  enq_src1_tag,
  input  logic [TAG_W-1:0]  enq_src2_tag,
  input  logic [DATA_W-1:0] enq_src1_val,
  input  logic [DATA_W-1:0] enq_src2_val,
  input  logic              enq_src1_filled,
  input  logic              enq_src2_filled,
  input  logic              enq_pred_taken,
  input  logic [ADDR_W-1:0] enq_target,
  input  logic [ADDR_W-1:0] enq_fallthru,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              clear,
  input  logic              deq,
  output logic              head_ready,
  output logic [TAG_W-1:0]  head_tag,
  output br_op_t            head_op,
  output logic [DATA_W-1:0] head_a,
  output logic [DATA_W-1:0] head_b,
  output logic              head_pred_taken,
  output logic [ADDR_W-1:0] head_target,
  output logic [ADDR_W-1:0] head_fallthru
);

  localparam int unsigned Depth = 1 << DEPTH_W;

  typedef logic [DEPTH_W:0] ptr_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    br_op_t            op;
    logic [TAG_W-1:0]  s1_tag;
    logic [DATA_W-1:0] s1_val;
    logic              s1_filled;
    logic [TAG_W-1:0]  s2_tag;
    logic [DATA_W-1:0] s2_val;
    logic              s2_filled;
    logic              pred_taken;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] fallthru;
  } entry_t;

  entry_t ent_q [Depth];
  entry_t ent_d [Depth];
  entry_t new_ent;
  ptr_t   head_q, head_d, tail_q, tail_d;
  logic   full, empty, enq;

  logic [DEPTH_W-1:0] head_idx, tail_idx;
  assign head_idx = head_q[DEPTH_W-1:0];
  assign tail_idx = tail_q[DEPTH_W-1:0];

  // Pointers carry one extra wrap bit: equal index with differing MSB means full.
  assign full  = (head_q[DEPTH_W] != tail_q[DEPTH_W]) && (head_idx == tail_idx);
  assign empty = (head_q == tail_q);
  assign enq_ready = ~full;
  assign enq       = enq_valid & ~full & ~clear;

  assign head_ready = ~empty & ent_q[head_idx].valid &
                      ent_q[head_idx].s1_filled & ent_q[head_idx].s2_filled;
  assign head_tag        = ent_q[head_idx].tag;
  assign head_op         = ent_q[head_idx].op;
  assign head_a          = ent_q[head_idx].s1_val;
  assign head_b          = ent_q[head_idx].s2_val;
  assign head_pred_taken = ent_q[head_idx].pred_taken;
  assign head_target     = ent_q[head_idx].target;
  assign head_fallthru   = ent_q[head_idx].fallthru;

  // Incoming entry, with a same-cycle CDB hit folded in.
  always_comb begin
    new_ent            = '0;
    new_ent.valid      = 1'b1;
    new_ent.tag        = enq_tag;
    new_ent.op         = enq_op;
    new_ent.s1_tag     = enq_src1_tag;
    new_ent.s1_val     = enq_src1_val;
    new_ent.s1_filled  = enq_src1_filled;
    new_ent.s2_tag     = enq_src2_tag;
    new_ent.s2_val     = enq_src2_val;
    new_ent.s2_filled  = enq_src2_filled;
    new_ent.pred_taken = enq_pred_taken;
    new_ent.target     = enq_target;
    new_ent.fallthru   = enq_fallthru;
    if (cdb_valid && !enq_src1_filled && (enq_src1_tag == cdb_tag)) begin
      new_ent.s1_val    = cdb_data;
      new_ent.s1_filled = 1'b1;
    end
    if (cdb_valid && !enq_src2_filled && (enq_src2_tag == cdb_tag)) begin
      new_ent.s2_val    = cdb_data;
      new_ent.s2_filled = 1'b1;
    end
  end

  always_comb begin
    ent_d  = ent_q;
    head_d = head_q;
    tail_d = tail_q;
    if (cdb_valid) begin
      for (int i = 0; i < Depth; i++) begin
        if (ent_q[i].valid && !ent_q[i].s1_filled && (ent_q[i].s1_tag == cdb_tag)) begin
          ent_d[i].s1_val    = cdb_data;
          ent_d[i].s1_filled = 1'b1;
        end
        if (ent_q[i].valid && !ent_q[i].s2_filled && (ent_q[i].s2_tag == cdb_tag)) begin
          ent_d[i].s2_val    = cdb_data;
          ent_d[i].s2_filled = 1'b1;
        end
      end
    end
    if (deq) begin
      ent_d[head_idx].valid = 1'b0;
      head_d = head_q + 1'b1;
    end
    if (enq) begin
      ent_d[tail_idx] = new_ent;
      tail_d = tail_q + 1'b1;
    end
    if (clear) begin
      for (int i = 0; i < Depth; i++) begin
        ent_d[i].valid = 1'b0;
      end
      head_d = '0;
      tail_d = '0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ent_q  <= '{default: '0};
      head_q <= '0;
      tail_q <= '0;
    end else begin
      ent_q  <= ent_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution unit: in-order queue feeding one execute register with mispredict redirect.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = CRAM_ADDR_W,
  parameter int unsigned TAG_W   = RSV_ID_W,
  parameter int unsigned DEPTH_W = BR_DEPTH_W
) (
  input logic                clk,
  input logic                nrst,
  branch_resolve_unit_if.slave bus
);

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    br_op_t            op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              pred_taken;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] fallthru;
  } exec_t;

  exec_t             e_q, e_d;
  logic              head_ready, issue, taken, miss;
  logic [TAG_W-1:0]  head_tag;
  br_op_t            head_op;
  logic [DATA_W-1:0] head_a, head_b;
  logic              head_pred_taken;
  logic [ADDR_W-1:0] head_target, head_fallthru;

  // A resolving mispredict squashes everything still queued, so nothing issues alongside it.
  assign issue = head_ready & ~bus.flush & ~miss;

  branch_resolve_unit_queue #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .TAG_W   (TAG_W),
    .DEPTH_W (DEPTH_W)
  ) u_queue (
    .clk             (clk),
    .nrst            (nrst),
    .enq_valid       (bus.i_valid),
    .enq_ready       (bus.i_ready),
    .enq_tag         (bus.i_tag),
    .enq_op          (br_op_t'(bus.i_op)),
    .enq_src1_tag    (bus.i_src1_tag),
    .enq_src2_tag    (bus.i_src2_tag),
    .enq_src1_val    (bus.i_src1_val),
    .enq_src2_val    (bus.i_src2_val),
    .enq_src1_filled (bus.i_src1_filled),
    .enq_src2_filled (bus.i_src2_filled),
    .enq_pred_taken  (bus.i_pred_taken),
    .enq_target      (bus.i_target),
    .enq_fallthru    (bus.i_fallthru),
    .cdb_valid       (bus.cdb_valid),
    .cdb_tag         (bus.cdb_tag),
    .cdb_data        (bus.cdb_data),
    .clear           (bus.flush | miss),
    .deq             (issue),
    .head_ready      (head_ready),
    .head_tag        (head_tag),
    .head_op         (head_op),
    .head_a          (head_a),
    .head_b          (head_b),
    .head_pred_taken (head_pred_taken),
    .head_target     (head_target),
    .head_fallthru   (head_fallthru)
  );

  always_comb begin
    case (e_q.op)
      BrBeq:   taken = (e_q.a == e_q.b);
      BrBne:   taken = (e_q.a != e_q.b);
      BrBlt:   taken = ($signed(e_q.a) < $signed(e_q.b));
      BrBge:   taken = ($signed(e_q.a) >= $signed(e_q.b));
      BrBltu:  taken = (e_q.a < e_q.b);
      BrBgeu:  taken = (e_q.a >= e_q.b);
      BrJal:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  assign miss = e_q.valid & (taken != e_q.pred_taken);

  // E holds zeros whenever it is idle, so the tag output needs no gating.
  always_comb begin
    e_d = '0;
    if (issue) begin
      e_d.valid      = 1'b1;
      e_d.tag        = head_tag;
      e_d.op         = head_op;
      e_d.a          = head_a;
      e_d.b          = head_b;
      e_d.pred_taken = head_pred_taken;
      e_d.target     = head_target;
      e_d.fallthru   = head_fallthru;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      e_q <= '0;
    end else begin
      e_q <= e_d;
    end
  end

  assign bus.o_valid       = e_q.valid;
  assign bus.o_tag         = e_q.tag;
  assign bus.o_taken       = e_q.valid & taken;
  assign bus.pred_miss     = miss;
  assign bus.pred_miss_dst = miss ? (taken ? e_q.target : e_q.fallthru) : '0;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: ordering, compares, backpressure, squash, flush, reset.
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;

  logic clk;
  logic nrst;
  int   n_pass;
  int   n_total;

  branch_resolve_unit_if #(.DATA_W(32), .ADDR_W(16), .TAG_W(6)) bus ();

  branch_resolve_unit #(
    .DATA_W  (32),
    .ADDR_W  (16),
    .TAG_W   (6),
    .DEPTH_W (2)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", name, obs, exp);
  endtask

  task automatic disp(input logic [5:0] tag, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic f1, input logic f2,
                      input logic [5:0] t1, input logic [5:0] t2,
                      input logic pred, input logic [15:0] tgt, input logic [15:0] fall);
    bus.i_valid       = 1'b1;
    bus.i_tag         = tag;
    bus.i_op          = op;
    bus.i_src1_val    = a;
    bus.i_src2_val    = b;
    bus.i_src1_filled = f1;
    bus.i_src2_filled = f2;
    bus.i_src1_tag    = t1;
    bus.i_src2_tag    = t2;
    bus.i_pred_taken  = pred;
    bus.i_target      = tgt;
    bus.i_fallthru    = fall;
  endtask

  task automatic cdb(input logic v, input logic [5:0] tag, input logic [31:0] data);
    bus.cdb_valid = v;
    bus.cdb_tag   = tag;
    bus.cdb_data  = data;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    nrst    = 1'b0;
    bus.flush = 1'b0;
    disp(6'd0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 16'd0, 16'd0);
    bus.i_valid = 1'b0;
    cdb(1'b0, 6'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_o_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_i_ready", 64'(bus.i_ready), 64'd1);
    chk("rst_o_tag", 64'(bus.o_tag), 64'd0);
    chk("rst_o_taken", 64'(bus.o_taken), 64'd0);
    chk("rst_pred_miss", 64'(bus.pred_miss), 64'd0);
    chk("rst_miss_dst", 64'(bus.pred_miss_dst), 64'd0);
    nrst = 1'b1;
    step();

    // Back-to-back BEQ 5,5 and BNE 3,3
    disp(6'd1, 3'd0, 32'd5, 32'd5, 1'b1, 1'b1, 6'd0, 6'd0, 1'b1, 16'h0100, 16'h0104);
    step();
    disp(6'd2, 3'd1, 32'd3, 32'd3, 1'b1, 1'b1, 6'd0, 6'd0, 1'b0, 16'h0200, 16'h0204);
    step();
    bus.i_valid = 1'b0;
    chk("beq_valid", 64'(bus.o_valid), 64'd1);
    chk("beq_tag", 64'(bus.o_tag), 64'd1);
    chk("beq_taken", 64'(bus.o_taken), 64'd1);
    chk("beq_miss", 64'(bus.pred_miss), 64'd0);
    step();
    chk("bne_valid", 64'(bus.o_valid), 64'd1);
    chk("bne_tag", 64'(bus.o_tag), 64'd2);
    chk("bne_taken", 64'(bus.o_taken), 64'd0);
    chk("bne_miss", 64'(bus.pred_miss), 64'd0);
    step();
    chk("b2b_idle", 64'(bus.o_valid), 64'd0);

    // Signed vs unsigned less-than
    disp(6'd3, 3'd2, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 6'd0, 6'd0, 1'b0, 16'h0300, 16'h0304);
    step();
    bus.i_valid = 1'b0;
    step();
    chk("blt_taken", 64'(bus.o_taken), 64'd1);
    chk("blt_miss", 64'(bus.pred_miss), 64'd1);
    chk("blt_dst", 64'(bus.pred_miss_dst), 64'h0300);
    step();
    disp(6'd4, 3'd4, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 6'd0, 6'd0, 1'b0, 16'h0400, 16'h0404);
    step();
    bus.i_valid = 1'b0;
    step();
    chk("bltu_valid", 64'(bus.o_valid), 64'd1);
    chk("bltu_taken", 64'(bus.o_taken), 64'd0);
    chk("bltu_miss", 64'(bus.pred_miss), 64'd0);
    chk("bltu_dst", 64'(bus.pred_miss_dst), 64'd0);
    step();

    // Head waits on tag 3; ready entry behind it must not bypass
    disp(6'd5, 3'd0, 32'd0, 32'd7, 1'b0, 1'b1, 6'd3, 6'd0, 1'b1, 16'h0500, 16'h0504);
    step();
    disp(6'd6, 3'd1, 32'd1, 32'd2, 1'b1, 1'b1, 6'd3, 6'd3, 1'b1, 16'h0600, 16'h0604);
    step();
    bus.i_valid = 1'b0;
    step();
    chk("stall_no_bypass", 64'(bus.o_valid), 64'd0);
    step();
    step();
    cdb(1'b1, 6'd3, 32'd7);
    step();
    cdb(1'b0, 6'd0, 32'd0);
    chk("cdb_no_same_cycle", 64'(bus.o_valid), 64'd0);
    step();
    chk("wake_head_tag", 64'(bus.o_tag), 64'd5);
    chk("wake_head_taken", 64'(bus.o_taken), 64'd1);
    chk("wake_head_miss", 64'(bus.pred_miss), 64'd0);
    step();
    chk("wake_next_tag", 64'(bus.o_tag), 64'd6);
    chk("wake_next_taken", 64'(bus.o_taken), 64'd1);
    step();
    chk("wake_idle", 64'(bus.o_valid), 64'd0);

    // Fill, backpressure, wrap with order preserved
    disp(6'd10, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1, 6'd9, 6'd0, 1'b1, 16'h0A00, 16'h0A04);
    step();
    for (int k = 11; k <= 13; k++) begin
      disp(6'(k), 3'd6, 32'd0, 32'd0, 1'b1, 1'b1, 6'd0, 6'd0, 1'b1, 16'h0B00, 16'h0B04);
      step();
    end
    chk("full_not_ready", 64'(bus.i_ready), 64'd0);
    disp(6'd14, 3'd6, 32'd0, 32'd0, 1'b1, 1'b1, 6'd0, 6'd0, 1'b1, 16'h0B00, 16'h0B04);
    cdb(1'b1, 6'd9, 32'd0);
    step();
    cdb(1'b0, 6'd0, 32'd0);
    chk("full_still_not_ready", 64'(bus.i_ready), 64'd0);
    step();
    chk("full_issue_tag", 64'(bus.o_tag), 64'd10);
    chk("full_issue_valid", 64'(bus.o_valid), 64'd1);
    chk("ready_after_issue", 64'(bus.i_ready), 64'd1);
    for (int k = 0; k < 5; k++) begin
      disp(6'(14 + k), 3'd6, 32'd0, 32'd0, 1'b1, 1'b1, 6'd0, 6'd0, 1'b1, 16'h0B00, 16'h0B04);
      step();
      chk("wrap_order", 64'(bus.o_tag), 64'(11 + k));
    end
    bus.i_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("wrap_drain", 64'(bus.o_tag), 64'(16 + k));
    end
    step();
    chk("wrap_idle", 64'(bus.o_valid), 64'd0);

    // Mispredict squashes two younger entries and a concurrent dispatch
    disp(6'd20, 3'd0, 32'd0, 32'd2, 1'b0, 1'b1, 6'd8, 6'd0, 1'b1, 16'h1400, 16'h1404);
    step();
    disp(6'd21, 3'd6, 32'd0, 32'd0, 1'b1, 1'b1, 6'd0, 6'd0, 1'b1, 16'h1500, 16'h1504);
    step();
    disp(6'd22, 3'd6, 32'd0, 32'd0, 1'b1, 1'b1, 6'd0, 6'd0, 1'b1, 16'h1600, 16'h1604);
    step();
    bus.i_valid = 1'b0;
    cdb(1'b1, 6'd8, 32'd1);
    step();
    cdb(1'b0, 6'd0, 32'd0);
    step();
    chk("miss_tag", 64'(bus.o_tag), 64'd20);
    chk("miss_taken", 64'(bus.o_taken), 64'd0);
    chk("miss_flag", 64'(bus.pred_miss), 64'd1);
    chk("miss_dst", 64'(bus.pred_miss_dst), 64'h1404);
    disp(6'd23, 3'd6, 32'd0, 32'd0, 1'b1, 1'b1, 6'd0, 6'd0, 1'b1, 16'h1700, 16'h1704);
    step();
    bus.i_valid = 1'b0;
    chk("squash_valid", 64'(bus.o_valid), 64'd0);
    chk("squash_ready", 64'(bus.i_ready), 64'd1);
    step();
    chk("squash_quiet1", 64'(bus.o_valid), 64'd0);
    step();
    chk("squash_quiet2", 64'(bus.o_valid), 64'd0);

    // Flush with concurrent CDB hit and dispatch
    disp(6'd30, 3'd0, 32'd0, 32'd5, 1'b0, 1'b1, 6'd7, 6'd0, 1'b1, 16'h1E00, 16'h1E04);
    step();
    disp(6'd31, 3'd6, 32'd0, 32'd0, 1'b1, 1'b1, 6'd0, 6'd0, 1'b1, 16'h1F00, 16'h1F04);
    step();
    disp(6'd32, 3'd6, 32'd0, 32'd0, 1'b1, 1'b1, 6'd0, 6'd0, 1'b1, 16'h2000, 16'h2004);
    cdb(1'b1, 6'd7, 32'd5);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.i_valid = 1'b0;
    cdb(1'b0, 6'd0, 32'd0);
    chk("flush_ready", 64'(bus.i_ready), 64'd1);
    for (int k = 0; k < 3; k++) begin
      chk("flush_quiet", 64'(bus.o_valid), 64'd0);
      step();
    end

    // Asynchronous reset mid-operation
    disp(6'd40, 3'd6, 32'd0, 32'd0, 1'b1, 1'b1, 6'd0, 6'd0, 1'b1, 16'h2800, 16'h2804);
    step();
    disp(6'd41, 3'd6, 32'd0, 32'd0, 1'b1, 1'b1, 6'd0, 6'd0, 1'b1, 16'h2900, 16'h2904);
    step();
    bus.i_valid = 1'b0;
    chk("pre_rst_valid", 64'(bus.o_valid), 64'd1);
    nrst = 1'b0;
    #1;
    chk("arst_o_valid", 64'(bus.o_valid), 64'd0);
    chk("arst_o_tag", 64'(bus.o_tag), 64'd0);
    chk("arst_o_taken", 64'(bus.o_taken), 64'd0);
    chk("arst_i_ready", 64'(bus.i_ready), 64'd1);
    #1;
    nrst = 1'b1;
    step();
    chk("post_rst_empty", 64'(bus.o_valid), 64'd0);
    chk("post_rst_miss", 64'(bus.pred_miss), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
